// File: rtl/router_pkg.sv
// Shared types, widths and helpers for the router packet source.
package router_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned BYTE_W = 8;

    localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_PARITY  = 2'd3
    } tx_state_t;

    // Router header byte: length in the upper six bits, destination in the lower two.
    function automatic logic [BYTE_W-1:0] build_header(input logic [ADDR_W-1:0] addr,
                                                       input logic [LEN_W-1:0]  len);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// Byte FIFO with first-word-fall-through read data; pointers and count clear on reset.
module router_tx_fifo
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      push,
    input  logic                      pop,
    input  logic [BYTE_W-1:0]         wr_data,
    output logic [BYTE_W-1:0]         rd_data_c,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;
    logic [CW-1:0]     count_nxt;

    // A push while full is dropped even if a pop happens on the same edge.
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: header, buffered payload, then XOR parity byte.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      wr_en,
    input  logic [BYTE_W-1:0]         wr_data,
    output logic                      fifo_full,
    output logic [$clog2(DEPTH):0]    fifo_count,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         dest_addr,
    input  logic [LEN_W-1:0]          payload_len,
    output logic                      tx_ready,
    output logic                      req_err,
    input  logic                      busy,
    output logic [BYTE_W-1:0]         data_out,
    output logic                      pkt_valid,
    output logic                      done
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [BYTE_W-1:0] data_nxt;
    logic              pkt_valid_nxt;
    logic              req_err_nxt;
    logic              done_nxt;
    logic [BYTE_W-1:0] parity_acc;
    logic [BYTE_W-1:0] parity_nxt;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  remaining_nxt;
    logic              pop_c;
    logic              accept_c;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_rd_c;

    router_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (wr_en),
        .pop       (pop_c),
        .wr_data   (wr_data),
        .rd_data_c (fifo_rd_c),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Requiring the whole payload up front guarantees no gaps once the packet starts.
    assign accept_c = start
                   && (dest_addr != ILLEGAL_ADDR)
                   && (payload_len != '0)
                   && (fifo_count >= CW'(payload_len));

    always_comb begin
        state_nxt     = state;
        data_nxt      = data_out;
        pkt_valid_nxt = pkt_valid;
        req_err_nxt   = 1'b0;
        done_nxt      = 1'b0;
        parity_nxt    = parity_acc;
        remaining_nxt = remaining;
        pop_c         = 1'b0;

        unique case (state)
            ST_IDLE: begin
                pkt_valid_nxt = 1'b0;
                if (start) begin
                    if (accept_c) begin
                        data_nxt      = build_header(dest_addr, payload_len);
                        parity_nxt    = build_header(dest_addr, payload_len);
                        pkt_valid_nxt = 1'b1;
                        remaining_nxt = payload_len;
                        state_nxt     = ST_HEADER;
                    end else begin
                        req_err_nxt = 1'b1;
                    end
                end
            end
            ST_HEADER, ST_PAYLOAD: begin
                if (!busy) begin
                    if (remaining != '0 && !fifo_empty) begin
                        pop_c         = 1'b1;
                        data_nxt      = fifo_rd_c;
                        parity_nxt    = parity_acc ^ fifo_rd_c;
                        remaining_nxt = remaining - LEN_W'(1);
                        state_nxt     = ST_PAYLOAD;
                    end else begin
                        data_nxt      = parity_acc;
                        pkt_valid_nxt = 1'b0;
                        state_nxt     = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (!busy) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                pkt_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            data_out   <= '0;
            pkt_valid  <= 1'b0;
            req_err    <= 1'b0;
            done       <= 1'b0;
            tx_ready   <= 1'b1;
            parity_acc <= '0;
            remaining  <= '0;
        end else begin
            state      <= state_nxt;
            data_out   <= data_nxt;
            pkt_valid  <= pkt_valid_nxt;
            req_err    <= req_err_nxt;
            done       <= done_nxt;
            tx_ready   <= (state_nxt == ST_IDLE);
            parity_acc <= parity_nxt;
            remaining  <= remaining_nxt;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: fixed vector table, directed corner sequences, random traffic vs packet model.
module tb_router_pkt_tx;
    import router_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          resetn;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          start;
    logic [1:0]    dest_addr;
    logic [5:0]    payload_len;
    logic          tx_ready;
    logic          req_err;
    logic          busy;
    logic [7:0]    data_out;
    logic          pkt_valid;
    logic          done;

    router_pkt_tx #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .fifo_full   (fifo_full),
        .fifo_count  (fifo_count),
        .start       (start),
        .dest_addr   (dest_addr),
        .payload_len (payload_len),
        .tx_ready    (tx_ready),
        .req_err     (req_err),
        .busy        (busy),
        .data_out    (data_out),
        .pkt_valid   (pkt_valid),
        .done        (done)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Packet-level model: buffered bytes, the packet being sent, and which byte is on the wire.
    logic [7:0] m_q[$];
    logic [7:0] m_pkt[$];
    int         m_idx;
    logic [7:0] m_data;
    logic       m_valid;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       st;
        logic [1:0] ad;
        logic [5:0] ln;
        logic       bz;
        logic [7:0] e_data;
        logic       e_valid;
        logic       e_done;
        logic       e_err;
        logic       e_ready;
        int         e_count;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pkt.delete();
        m_idx   = -1;
        m_data  = 8'h00;
        m_valid = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, then compare every output against it.
    task automatic cycle(input logic we, input logic [7:0] wd, input logic st,
                         input logic [1:0] ad, input logic [5:0] ln, input logic bz);
        logic       exp_done;
        logic       exp_err;
        logic       full_before;
        logic [7:0] hdr;
        logic [7:0] par;
        int         last;
        wr_en = we; wr_data = wd; start = st; dest_addr = ad; payload_len = ln; busy = bz;
        full_before = (m_q.size() >= int'(DEPTH));
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (m_idx < 0) begin
            if (st) begin
                if (ad != 2'd3 && ln != 6'd0 && m_q.size() >= int'(ln)) begin
                    hdr = {ln, ad};
                    par = hdr;
                    m_pkt.delete();
                    m_pkt.push_back(hdr);
                    for (int i = 0; i < int'(ln); i++) begin
                        m_pkt.push_back(m_q[i]);
                        par = par ^ m_q[i];
                    end
                    m_pkt.push_back(par);
                    m_idx   = 0;
                    m_data  = hdr;
                    m_valid = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end else if (!bz) begin
            last = m_pkt.size() - 1;
            if (m_idx == last) begin
                m_idx    = -1;
                exp_done = 1'b1;
            end else begin
                m_idx++;
                if (m_idx < last) void'(m_q.pop_front());
                m_data  = m_pkt[m_idx];
                m_valid = (m_idx < last);
            end
        end
        if (we && !full_before) m_q.push_back(wd);
        @(posedge clock);
        #1;
        chk("data_out",   32'(data_out),   32'(m_data));
        chk("pkt_valid",  32'(pkt_valid),  32'(m_valid));
        chk("done",       32'(done),       32'(exp_done));
        chk("req_err",    32'(req_err),    32'(exp_err));
        chk("tx_ready",   32'(tx_ready),   32'(m_idx < 0));
        chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("fifo_full",  32'(fifo_full),  32'(m_q.size() == int'(DEPTH)));
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 8'h00, 1'b0, 2'd0, 6'd0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_data_out"},   32'(data_out),   32'h0);
        chk({tag, "_pkt_valid"},  32'(pkt_valid),  32'h0);
        chk({tag, "_req_err"},    32'(req_err),    32'h0);
        chk({tag, "_done"},       32'(done),       32'h0);
        chk({tag, "_fifo_count"}, 32'(fifo_count), 32'h0);
        chk({tag, "_fifo_full"},  32'(fifo_full),  32'h0);
        chk({tag, "_tx_ready"},   32'(tx_ready),   32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0;
        dest_addr = 2'd0; payload_len = 6'd0; busy = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("por");
        resetn = 1'b1;

        // Basic packet, illegal address, zero length, tiny packet; expected values hand-derived.
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 2'd0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 2'd0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 2'd0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 2'd1, 6'd3, 1'b0, 8'h0D, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 2'd0, 6'd0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 2'd0, 6'd0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 2'd0, 6'd0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 2'd0, 6'd0, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 2'd0, 6'd0, 1'b0, 8'h0D, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 2'd3, 6'd1, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        tbl[10] = '{1'b1, 8'hA5, 1'b1, 2'd0, 6'd0, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 2'd2, 6'd1, 1'b0, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 2'd0, 6'd0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 2'd0, 6'd0, 1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 2'd0, 6'd0, 1'b0, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b1, 0};

        for (int v = 0; v < 15; v++) begin
            cycle(tbl[v].we, tbl[v].wd, tbl[v].st, tbl[v].ad, tbl[v].ln, tbl[v].bz);
            chk($sformatf("tbl%0d_data", v),  32'(data_out),   32'(tbl[v].e_data));
            chk($sformatf("tbl%0d_valid", v), 32'(pkt_valid),  32'(tbl[v].e_valid));
            chk($sformatf("tbl%0d_done", v),  32'(done),       32'(tbl[v].e_done));
            chk($sformatf("tbl%0d_err", v),   32'(req_err),    32'(tbl[v].e_err));
            chk($sformatf("tbl%0d_ready", v), 32'(tx_ready),   32'(tbl[v].e_ready));
            chk($sformatf("tbl%0d_count", v), 32'(fifo_count), 32'(tbl[v].e_count));
        end

        // Back-pressure while 0x22 is on the wire.
        cycle(1'b1, 8'h11, 1'b0, 2'd0, 6'd0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 2'd0, 6'd0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 2'd0, 6'd0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 2'd1, 6'd3, 1'b0);
        idle_cycle();
        idle_cycle();
        chk("bp_first_22", 32'(data_out), 32'h22);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 2'd0, 6'd0, 1'b1);
            chk("bp_hold_data", 32'(data_out), 32'h22);
            chk("bp_hold_count", 32'(fifo_count), 32'd1);
            chk("bp_hold_valid", 32'(pkt_valid), 32'd1);
        end
        idle_cycle();
        chk("bp_33", 32'(data_out), 32'h33);
        idle_cycle();
        chk("bp_parity", 32'(data_out), 32'h0D);
        idle_cycle();
        chk("bp_done", 32'(done), 32'd1);

        // Too-short FIFO: rejected, nothing popped; then drain it.
        cycle(1'b1, 8'h01, 1'b0, 2'd0, 6'd0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 2'd0, 6'd0, 1'b0);
        cycle(1'b1, 8'h03, 1'b0, 2'd0, 6'd0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 2'd0, 6'd5, 1'b0);
        chk("rej_len_err", 32'(req_err), 32'd1);
        chk("rej_len_count", 32'(fifo_count), 32'd3);
        chk("rej_len_ready", 32'(tx_ready), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 2'd0, 6'd3, 1'b0);
        repeat (5) idle_cycle();
        chk("rej_drain_count", 32'(fifo_count), 32'd0);

        // Capacity: 65 writes, last dropped; then a maximum-length packet.
        for (int i = 0; i < 65; i++) cycle(1'b1, 8'(i), 1'b0, 2'd0, 6'd0, 1'b0);
        chk("cap_full", 32'(fifo_full), 32'd1);
        chk("cap_count", 32'(fifo_count), 32'd64);
        cycle(1'b0, 8'h00, 1'b1, 2'd2, 6'd63, 1'b0);
        chk("cap_header", 32'(data_out), 32'hFE);
        for (int k = 0; k < 200 && !done; k++) idle_cycle();
        chk("cap_done_seen", 32'(done), 32'd1);
        chk("cap_left", 32'(fifo_count), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 2'd0, 6'd1, 1'b0);
        idle_cycle();
        chk("cap_leftover_byte", 32'(data_out), 32'd63);
        repeat (2) idle_cycle();

        // Abort: reset while payload byte 2 of 5 is presented.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 2'd0, 6'd0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 2'd1, 6'd5, 1'b0);
        idle_cycle();
        idle_cycle();
        chk("abort_byte2", 32'(data_out), 32'hA1);
        resetn = 1'b0;
        model_reset();
        #1;
        check_reset_values("abort");
        @(posedge clock);
        #1;
        resetn = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0, 2'd0, 6'd0, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0, 2'd0, 6'd0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 2'd0, 6'd2, 1'b0);
        chk("post_abort_hdr", 32'(data_out), 32'h08);
        repeat (3) idle_cycle();
        chk("post_abort_parity", 32'(data_out), 32'(8'h08 ^ 8'h5A ^ 8'hC3));
        idle_cycle();

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 99) < 15), 2'($urandom_range(0, 3)),
                  6'($urandom_range(0, 12)), ($urandom_range(0, 99) < 30));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
